serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_rx.sv | 115 +++++++++++
 tb/tb_serial_frame_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, N data bits LSB-first, optional even parity, stop bit.
// Delivers each good frame into a one-deep output register with a valid/ready handshake.
module serial_frame_rx #(
    parameter int N         = 5,
    parameter int PARITY_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_en,
    input  logic         ready,
    output logic [N-1:0] q,
    output logic         valid,
    output logic         par_err,
    output logic         frame_err,
    output logic         overrun,
    output logic         busy,
    output logic [7:0]   frame_cnt
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  bitCnt_q;
    logic [N-1:0]   shreg_q;
    logic           parBit_q;
    logic [N-1:0]   word_q;
    logic           valid_q;
    logic           parErr_q;
    logic           frameErr_q;
    logic           overrun_q;
    logic [7:0]     frameCnt_q;
    logic           parityFail;

    // Even parity over data plus parity bit must be zero; without a parity bit nothing can fail.
    always_comb begin
        parityFail = 1'b0;
        if (PARITY_EN != 0) begin
            parityFail = (^shreg_q) ^ parBit_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            shreg_q    <= '0;
            parBit_q   <= 1'b0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            parErr_q   <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
            // Handshake may retire the word on any edge; a stop-bit load below overrides it.
            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
            if (sin_en) begin
                case (state_q)
                    IDLE: begin
                        if (!sin) begin
                            bitCnt_q <= '0;
                            state_q  <= DATA;
                        end
                    end
                    DATA: begin
                        shreg_q  <= {sin, shreg_q[N-1:1]};
                        bitCnt_q <= bitCnt_q + CW'(1);
                        if (bitCnt_q == CW'(N - 1)) begin
                            state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        parBit_q <= sin;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        if (!sin) begin
                            frameErr_q <= 1'b1;
                        end else if (!valid_q || ready) begin
                            word_q     <= shreg_q;
                            valid_q    <= 1'b1;
                            parErr_q   <= parityFail;
                            frameCnt_q <= frameCnt_q + 8'd1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign q         = word_q;
    assign valid     = valid_q;
    assign par_err   = parErr_q;
    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frameCnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed frames with literal expectations plus
// randomized traffic compared every cycle against a frame-position reference model.
module tb_serial_frame_rx;

    localparam int N      = 5;
    localparam int PAR_EN = 1;
    localparam int STOP_POS = N + PAR_EN;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sin = 1'b1;
    logic         sin_en = 1'b0;
    logic         ready = 1'b1;
    logic [N-1:0] q;
    logic         valid;
    logic         par_err;
    logic         frame_err;
    logic         overrun;
    logic         busy;
    logic [7:0]   frame_cnt;

    int checks = 0;
    int errors = 0;
    bit randReady = 1'b0;

    serial_frame_rx #(.N(N), .PARITY_EN(PAR_EN)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_en    (sin_en),
        .ready     (ready),
        .q         (q),
        .valid     (valid),
        .par_err   (par_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the position of the next expected bit within the frame
    // (-1 while waiting for a start bit) and assembles the word by bit index.
    int           mPos = -1;
    logic [N-1:0] mWord = '0;
    logic         mPar = 1'b0;
    logic [N-1:0] expQ = '0;
    logic         expValid = 1'b0;
    logic         expPerr = 1'b0;
    logic         expFerr = 1'b0;
    logic         expOvr = 1'b0;
    int           expCnt = 0;
    logic         oldValid;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mPos = -1; mWord = '0; mPar = 1'b0; expQ = '0; expValid = 1'b0;
                expPerr = 1'b0; expFerr = 1'b0; expOvr = 1'b0; expCnt = 0;
            end else begin
                oldValid = expValid;
                expFerr = 1'b0;
                expOvr  = 1'b0;
                if (oldValid && ready) expValid = 1'b0;
                if (sin_en) begin
                    if (mPos < 0) begin
                        if (!sin) begin
                            mPos  = 0;
                            mWord = '0;
                        end
                    end else if (mPos < N) begin
                        mWord[mPos] = sin;
                        mPos++;
                    end else if (mPos < STOP_POS) begin
                        mPar = sin;
                        mPos++;
                    end else begin
                        if (!sin) begin
                            expFerr = 1'b1;
                        end else if (!oldValid || ready) begin
                            expQ     = mWord;
                            expValid = 1'b1;
                            expPerr  = (PAR_EN != 0) ? (($countones(mWord) + int'(mPar)) % 2 == 1) : 1'b0;
                            expCnt   = (expCnt + 1) % 256;
                        end else begin
                            expOvr = 1'b1;
                        end
                        mPos = -1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, all registered outputs must match the model.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            checkOutput("model_q", 32'(q), 32'(expQ));
            checkOutput("model_valid", 32'(valid), 32'(expValid));
            checkOutput("model_busy", 32'(busy), 32'(mPos >= 0));
            checkOutput("model_frame_err", 32'(frame_err), 32'(expFerr));
            checkOutput("model_overrun", 32'(overrun), 32'(expOvr));
            checkOutput("model_frame_cnt", 32'(frame_cnt), 32'(expCnt));
            if (expValid) checkOutput("model_par_err", 32'(par_err), 32'(expPerr));
        end
    end

    task automatic applyStimulus(input logic b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            sin_en = 1'b0;
            sin    = 1'($urandom_range(0, 1));
            if (randReady) ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        sin    = b;
        sin_en = 1'b1;
        if (randReady) ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #2;
    endtask

    task automatic idleCycle();
        @(negedge clk);
        sin_en = 1'b0;
        sin    = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic sendFrame(input logic [N-1:0] data, input logic pbit, input logic sbit, input int maxGap);
        applyStimulus(1'b0, (maxGap > 0) ? $urandom_range(0, maxGap) : 0);
        for (int i = 0; i < N; i++) applyStimulus(data[i], (maxGap > 0) ? $urandom_range(0, maxGap) : 0);
        if (PAR_EN != 0) applyStimulus(pbit, (maxGap > 0) ? $urandom_range(0, maxGap) : 0);
        applyStimulus(sbit, (maxGap > 0) ? $urandom_range(0, maxGap) : 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst    = 1'b0;
        sin_en = 1'b0;
        sin    = 1'b1;
        #1;
        checkOutput("rst_q", 32'(q), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("rst_err_flags", {29'd0, par_err, frame_err, overrun}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [N-1:0] d;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Good frame 10110 with correct even parity.
        ready = 1'b1;
        sendFrame(5'b10110, 1'b1, 1'b1, 0);
        checkOutput("good_q", 32'(q), 32'h16);
        checkOutput("good_valid", 32'(valid), 32'd1);
        checkOutput("good_par_err", 32'(par_err), 32'd0);
        checkOutput("good_frame_cnt", 32'(frame_cnt), 32'd1);

        // Same frame with the wrong parity bit.
        sendFrame(5'b10110, 1'b0, 1'b1, 0);
        checkOutput("perr_q", 32'(q), 32'h16);
        checkOutput("perr_valid", 32'(valid), 32'd1);
        checkOutput("perr_par_err", 32'(par_err), 32'd1);

        // Stop bit sampled low.
        sendFrame(5'b00111, 1'b1, 1'b0, 0);
        checkOutput("ferr_pulse", 32'(frame_err), 32'd1);
        checkOutput("ferr_valid", 32'(valid), 32'd0);
        checkOutput("ferr_frame_cnt", 32'(frame_cnt), 32'd2);
        idleCycle();
        checkOutput("ferr_pulse_end", 32'(frame_err), 32'd0);

        // Consumer stalled: second frame overruns.
        doReset();
        ready = 1'b0;
        sendFrame(5'b00001, 1'b1, 1'b1, 0);
        checkOutput("ovr_first_q", 32'(q), 32'h01);
        sendFrame(5'b11111, 1'b1, 1'b1, 0);
        checkOutput("ovr_pulse", 32'(overrun), 32'd1);
        checkOutput("ovr_q_kept", 32'(q), 32'h01);
        checkOutput("ovr_valid", 32'(valid), 32'd1);
        checkOutput("ovr_frame_cnt", 32'(frame_cnt), 32'd1);
        idleCycle();
        checkOutput("ovr_pulse_end", 32'(overrun), 32'd0);

        // Reset in the middle of a frame, then a clean frame.
        doReset();
        ready = 1'b1;
        applyStimulus(1'b0, 0);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 0);
        applyStimulus(1'b0, 0);
        doReset();
        sendFrame(5'b01010, 1'b0, 1'b1, 0);
        checkOutput("midrst_q", 32'(q), 32'h0A);
        checkOutput("midrst_valid", 32'(valid), 32'd1);
        checkOutput("midrst_frame_cnt", 32'(frame_cnt), 32'd1);

        // 256 good frames with strobe gaps: the counter wraps back to zero.
        doReset();
        ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            d = N'($urandom);
            sendFrame(d, ^d, 1'b1, 2);
            if (i == 254) checkOutput("wrap_cnt_255", 32'(frame_cnt), 32'd255);
        end
        checkOutput("wrap_cnt_0", 32'(frame_cnt), 32'd0);

        // Randomized traffic: random ready, parity and stop errors, idle strobes, gaps.
        randReady = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, $urandom_range(0, 2));
            d = N'($urandom);
            sendFrame(d, (^d) ^ ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) != 0), 2);
        end
        randReady = 1'b0;
        ready = 1'b1;
        repeat (4) idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
